// File: rtl/axis_pixel_bridge.sv
// Pixel-stream to AXI4-Stream video bridge with FIFO, generated tlast, overflow resync and status.
// Optional AXIS_FRAME_CNT_EN adds o_frame_cnt, a wrapping count of accepted start-of-frame beats.
module axis_pixel_bridge #(
    parameter int unsigned COMP_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LINE_PIXELS = 640
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [COMP_W-1:0]               i_r,
    input  logic [COMP_W-1:0]               i_g,
    input  logic [COMP_W-1:0]               i_b,
    input  logic                            i_valid,
    input  logic                            i_sof,
    input  logic                            i_eol,
    input  logic                            i_fmt,
    input  logic                            i_clear,
    output logic [3*COMP_W-1:0]             tdata,
    output logic                            tvalid,
    input  logic                            tready,
    output logic                            tlast,
    output logic                            tuser,
    output logic                            o_overflow,
    output logic                            o_line_err,
    output logic [15:0]                     o_drop_cnt,
`ifdef AXIS_FRAME_CNT_EN
    output logic [15:0]                     o_frame_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

    localparam int unsigned DW = 3 * COMP_W;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DW + 2;
    localparam int unsigned CW = $clog2(LINE_PIXELS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrop} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic            wr_last_q;
    logic [CW-1:0]   col_q, col_d;
    logic            fmt_q, fmt_d;
    logic            overflow_q, overflow_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [DW-1:0]   out_data_q;
    logic            out_last_q, out_user_q, out_valid_q;

    logic            full, wr_en, drop, rd_en, readable;
    logic            eff_fmt, at_end, pix_last;
    logic [CW-1:0]   col_cur;
    logic [DW-1:0]   data_pk;
    logic [EW-1:0]   wr_entry;

    assign full = (level_q == LW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        drop    = 1'b0;
        if (i_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (i_sof && !full) begin
                        wr_en   = 1'b1;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (full) begin
                        drop    = 1'b1;
                        state_d = StDrop;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                StDrop: begin
                    if (i_sof && !full) begin
                        wr_en   = 1'b1;
                        state_d = StRun;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A sof pixel uses its own i_fmt; later pixels use the latched frame format.
    assign eff_fmt  = i_sof ? i_fmt : fmt_q;
    assign data_pk  = eff_fmt ? {i_r, i_g, i_b} : {i_r, i_b, i_g};
    assign col_cur  = i_sof ? '0 : col_q;
    assign at_end   = (col_cur == CW'(LINE_PIXELS - 1));
    assign pix_last = i_eol | at_end;
    assign wr_entry = {i_sof, pix_last, data_pk};

    always_comb begin
        col_d      = col_q;
        fmt_d      = fmt_q;
        overflow_d = i_clear ? 1'b0 : overflow_q;
        line_err_d = i_clear ? 1'b0 : line_err_q;
        drop_cnt_d = i_clear ? 16'd0 : drop_cnt_q;
        if (wr_en) begin
            col_d = pix_last ? '0 : col_cur + CW'(1);
            if (i_sof) fmt_d = i_fmt;
            if (i_eol && !at_end) line_err_d = 1'b1;
        end
        if (drop) begin
            if (full) overflow_d = 1'b1;
            if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    // An entry becomes readable one cycle after its write, keeping the write path off the output.
    assign readable = (level_q > LW'(wr_last_q));
    assign rd_en    = readable && (!out_valid_q || tready);
    assign level_d  = level_q + LW'(wr_en) - LW'(rd_en);

    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_last_q   <= 1'b0;
            col_q       <= '0;
            fmt_q       <= 1'b0;
            overflow_q  <= 1'b0;
            line_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            wr_last_q  <= wr_en;
            col_q      <= col_d;
            fmt_q      <= fmt_d;
            overflow_q <= overflow_d;
            line_err_q <= line_err_d;
            drop_cnt_q <= drop_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                out_data_q  <= mem_q[rd_ptr_q][DW-1:0];
                out_last_q  <= mem_q[rd_ptr_q][DW];
                out_user_q  <= mem_q[rd_ptr_q][DW+1];
                out_valid_q <= 1'b1;
            end else if (tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign tdata        = out_data_q;
    assign tlast        = out_last_q;
    assign tuser        = out_user_q;
    assign tvalid       = out_valid_q;
    assign o_overflow   = overflow_q;
    assign o_line_err   = line_err_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_fifo_level = level_q;

`ifdef AXIS_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
        end else if (out_valid_q && tready && out_user_q) begin
            frame_cnt_q <= (i_clear ? 16'd0 : frame_cnt_q) + 16'd1;
        end else if (i_clear) begin
            frame_cnt_q <= '0;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    // No frame counter in this build.
`endif

endmodule

// File: doc/axis_pixel_bridge.md
Name: axis_pixel_bridge

Overview:
- Parametrised successor to the single-shot pixel→AXI4-Stream interface in the camera capture path.
- Accepts one RGB pixel per cycle from the capture/CDC stage (already in aclk domain, no backpressure), buffers it in a FIFO and emits AXI4-Stream video toward VDMA/DDR.
- Adds configurable component width, FIFO depth and line length; generated tlast; selectable channel order; overflow detection with frame resync; error/status reporting.

Parameters:
- COMP_W, 8, bits per colour component; tdata width = 3*COMP_W.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- LINE_PIXELS, 640, active pixels per line; used for generated tlast and line checking.

Ports:
- aclk  in  1  stream clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- i_r, i_g, i_b  in  COMP_W each  pixel components.
- i_valid  in  1  pixel strobe; there is no ready back to the source.
- i_sof  in  1  first pixel of frame; qualified by i_valid.
- i_eol  in  1  last pixel of line; qualified by i_valid.
- i_fmt  in  1  0 = {R,B,G} (video-IP order, G in LSBs), 1 = {R,G,B}.
- i_clear  in  1  clears sticky status and drop counter.
- tdata  out  3*COMP_W  stream data.
- tvalid  out  1  stream valid.
- tready  in  1  stream ready.
- tlast  out  1  end of line.
- tuser  out  1  start of frame.
- o_overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- o_line_err  out  1  sticky: i_eol disagreed with LINE_PIXELS.
- o_drop_cnt  out  16  dropped pixels, saturating at 0xFFFF.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, excluding the output register.

Behaviour:
- Reset (async assert, sync release): every output is 0, FIFO empty, state IDLE, column counter 0, fmt latch 0.
- FSM, evaluated on cycles where i_valid=1:
  - IDLE: discards pixels, which are not counted. i_sof → RUN, and that pixel is written.
  - RUN: writes a pixel iff FIFO not full (registered level < FIFO_DEPTH; no same-cycle read bypass). If full: drop the pixel, set o_overflow, increment o_drop_cnt, go to DROP.
  - DROP: discards and counts every pixel until i_valid & i_sof & not full, then writes it and goes to RUN.
  - Pixels already in the FIFO always drain; a line truncated by overflow carries no tlast.
- i_fmt is latched on every written sof pixel and held for the whole frame.
- FIFO entry = packed data, tuser = i_sof, tlast = i_eol | (col == LINE_PIXELS-1).
- Column counter:
  - Counts written pixels; forced to 0 on a sof pixel, then incremented.
  - Wraps to 0 after any pixel that carries tlast.
  - o_line_err sets when i_eol arrives with col != LINE_PIXELS-1.
- Output stage:
  - One register; loaded from the FIFO when empty or when tvalid & tready.
  - Total capacity is FIFO_DEPTH+1 pixels.
  - tdata/tlast/tuser hold stable while tvalid & !tready.
- Latency: pixel written at edge N appears with tvalid=1 after edge N+2 when the FIFO and output register are empty.
- o_drop_cnt saturates at 0xFFFF.
- i_clear in the same cycle as a new error or drop: the new event wins, so the flag reads 1 and the counter reads 1.
- A sof arriving in RUN mid-line is accepted as a new frame; the column counter restarts. No error is flagged.

Optional Feature:
- Macro AXIS_FRAME_CNT_EN.
  - Defined: adds output o_frame_cnt [15:0]. Increments (wrapping) on each accepted beat with tuser=1, i.e. tvalid & tready & tuser. Resets to 0 and is cleared by i_clear.
  - Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold aresetn=0 while driving pixels → all outputs 0. Release, then drive pixels without sof → nothing emitted, o_drop_cnt=0.
- Basic line: COMP_W=8, LINE_PIXELS=4, fmt=0, tready=1. Pixels R/G/B=0x11/0x22/0x33 ×4 starting with sof → 4 beats, each tdata=0x113322. tuser on beat 0, tlast on beat 3. First tvalid 2 cycles after the sof write.
- Backpressure: FIFO_DEPTH=16, tready=0, 20 consecutive pixels from sof → 17 retained, o_overflow=1, o_drop_cnt=3. Raise tready → 17 beats in order, then stall.
- Resync: after an overflow, 5 pixels without sof → o_drop_cnt increases by 5. Next sof pixel → emitted with tuser=1, fmt=1 gives tdata={R,G,B}.
- Line error: LINE_PIXELS=4, i_eol on 3rd pixel → tlast on beat 2 and o_line_err=1. Pulse i_clear → o_line_err=0, o_drop_cnt=0.
- Mid-frame reset: assert aresetn with 8 pixels buffered → tvalid=0 immediately. After release, the FIFO is empty and o_fifo_level=0.
